// File: rtl/player_render_ctrl.sv
// Player tile renderer: erases the previously drawn tile and draws the current one
// (body plus direction marker) through the arbitrated VGA pixel-write port.
module player_render_ctrl #(
  parameter int         TILE_PX     = 8,
  parameter int         X_OFFSET    = 0,
  parameter int         Y_OFFSET    = 0,
  parameter logic [8:0] BG_COLOR    = 9'h000,
  parameter logic [8:0] BODY_COLOR  = 9'h1C0,
  parameter logic [8:0] ARROW_COLOR = 9'h1FF
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [4:0] x_position,
  input  logic [4:0] y_position,
  input  logic [1:0] dir,
  input  logic       grant,
  output logic       req,
  output logic [9:0] vga_x,
  output logic [8:0] vga_y,
  output logic [8:0] vga_color,
  output logic       vga_write,
  output logic       busy,
  output logic       render_done
);

  localparam int              CW     = $clog2(TILE_PX);
  localparam logic [CW-1:0]   LAST_C = CW'(TILE_PX - 1);
  localparam logic [CW-1:0]   MID_C  = CW'(TILE_PX / 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic          shadow_valid_r;
  logic [4:0]    sx_r, sy_r, tx_r, ty_r;
  logic [1:0]    sdir_r, tdir_r;
  logic [CW-1:0] px_r, py_r;

  logic          pos_diff_s, dir_diff_s, start_s, tile_last_s, marker_s;
  logic [4:0]    tile_x_s, tile_y_s;

  assign pos_diff_s  = (x_position != sx_r) || (y_position != sy_r);
  assign dir_diff_s  = (dir != sdir_r);
  assign start_s     = !shadow_valid_r || pos_diff_s || dir_diff_s;
  assign tile_last_s = (px_r == LAST_C) && (py_r == LAST_C);
  assign tile_x_s    = (state_r == ERASE) ? sx_r : tx_r;
  assign tile_y_s    = (state_r == ERASE) ? sy_r : ty_r;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; the erase pass is skipped when only the facing changed
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!shadow_valid_r) begin
          state_s = DRAW;
        end else if (pos_diff_s) begin
          state_s = ERASE;
        end else if (dir_diff_s) begin
          state_s = DRAW;
        end else begin
          state_s = IDLE;
        end
      end
      ERASE: begin
        if (grant && tile_last_s) begin
          state_s = DRAW;
        end else begin
          state_s = ERASE;
        end
      end
      DRAW: begin
        if (grant && tile_last_s) begin
          state_s = DONE;
        end else begin
          state_s = DRAW;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Target latch, raster counters (advance only on granted writes) and shadow update
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      shadow_valid_r <= 1'b0;
      sx_r   <= 5'd0;
      sy_r   <= 5'd0;
      sdir_r <= 2'd0;
      tx_r   <= 5'd0;
      ty_r   <= 5'd0;
      tdir_r <= 2'd0;
      px_r   <= '0;
      py_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          px_r <= '0;
          py_r <= '0;
          if (start_s) begin
            tx_r   <= x_position;
            ty_r   <= y_position;
            tdir_r <= dir;
          end
        end
        ERASE, DRAW: begin
          if (grant) begin
            if (px_r == LAST_C) begin
              px_r <= '0;
              py_r <= (py_r == LAST_C) ? '0 : py_r + 1'b1;
            end else begin
              px_r <= px_r + 1'b1;
            end
          end
        end
        DONE: begin
          sx_r           <= tx_r;
          sy_r           <= ty_r;
          sdir_r         <= tdir_r;
          shadow_valid_r <= 1'b1;
        end
        default: begin
          px_r <= '0;
          py_r <= '0;
        end
      endcase
    end
  end

  // Direction marker: a ray from the tile centre toward the facing side
  always_comb begin
    marker_s = 1'b0;
    case (tdir_r)
      2'b00:   marker_s = (py_r == MID_C) && (px_r >= MID_C);
      2'b01:   marker_s = (px_r == MID_C) && (py_r <= MID_C);
      2'b10:   marker_s = (py_r == MID_C) && (px_r <= MID_C);
      2'b11:   marker_s = (px_r == MID_C) && (py_r >= MID_C);
      default: marker_s = 1'b0;
    endcase
  end

  // Pixel port and status outputs
  always_comb begin
    req         = 1'b0;
    vga_write   = 1'b0;
    vga_x       = 10'd0;
    vga_y       = 9'd0;
    vga_color   = 9'd0;
    render_done = 1'b0;
    busy        = 1'b0;
    case (state_r)
      ERASE, DRAW: begin
        req       = 1'b1;
        vga_write = grant;
        vga_x     = 10'(X_OFFSET) + 10'(tile_x_s) * 10'(TILE_PX) + 10'(px_r);
        vga_y     = 9'(Y_OFFSET) + 9'(tile_y_s) * 9'(TILE_PX) + 9'(py_r);
        if (state_r == ERASE) begin
          vga_color = BG_COLOR;
        end else if (marker_s) begin
          vga_color = ARROW_COLOR;
        end else begin
          vga_color = BODY_COLOR;
        end
      end
      DONE:    render_done = 1'b1;
      IDLE:    render_done = 1'b0;
      default: render_done = 1'b0;
    endcase
    if (state_r != IDLE) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
  end

endmodule
